// File: rtl/tlcd_bus_scheduler.sv
// rtl/tlcd_bus_scheduler.sv - Text LCD bus owner: two-port round-robin write scheduler with HD44780 timing
module tlcd_bus_scheduler #(
  parameter int E_SETUP_CYC   = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int E_HOLD_CYC    = 2,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  input  logic       LOCK0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  input  logic       LOCK1,
  output logic       ACK1,
  output logic       BUSY,
  output logic       OWNER,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA
);

  // The single down-counter must hold the largest phase length minus one.
  localparam int MAX_A   = (E_SETUP_CYC > E_HIGH_CYC) ? E_SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_B   = (E_HOLD_CYC > CMD_WAIT_CYC) ? E_HOLD_CYC : CMD_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > LONG_WAIT_CYC) ? MAX_C : LONG_WAIT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(E_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(E_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q;
  logic             lock_q;
  logic             rs_q;
  logic [7:0]       data_q;

  logic             lock_eff;
  logic             elig0, elig1;
  logic             grant;
  logic             win;
  logic             long_cmd;
  logic             cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  // Clear display (01) and return home (02/03) need the long execution wait.
  assign long_cmd  = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

  assign BUSY      = (state_q != ST_IDLE);
  assign OWNER     = owner_q;
  assign TLCD_E    = (state_q == ST_PULSE);
  assign TLCD_RS   = rs_q;
  assign TLCD_DATA = data_q;
  assign TLCD_RW   = 1'b0;

  // Arbitration: a held lock only counts while the owner still asserts its LOCK input.
  always_comb begin
    lock_eff = lock_q & (owner_q ? LOCK1 : LOCK0);
    elig0    = REQ0 & (!lock_eff | !owner_q);
    elig1    = REQ1 & (!lock_eff | owner_q);
    win      = (elig0 & elig1) ? ~owner_q : elig1;
  end

  // State and phase counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: each phase runs until the counter reaches zero, then reloads for the next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    ACK0    = 1'b0;
    ACK1    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          grant   = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = long_cmd ? LONG_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          ACK0    = ~owner_q;
          ACK1    = owner_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant capture of owner, lock and byte; bus returns to zero when execution wait begins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q <= 1'b1;
      lock_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      if (grant) begin
        owner_q <= win;
        lock_q  <= win ? LOCK1 : LOCK0;
        rs_q    <= win ? RS1 : RS0;
        data_q  <= win ? DATA1 : DATA0;
      end else if ((state_q == ST_IDLE) && !lock_eff) begin
        lock_q <= 1'b0;
      end
      if ((state_q == ST_HOLD) && cnt_zero) begin
        rs_q   <= 1'b0;
        data_q <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_tlcd_bus_scheduler.sv
// tb/tb_tlcd_bus_scheduler.sv - self-checking bench for tlcd_bus_scheduler
module tb_tlcd_bus_scheduler;

  localparam int S = 1, H = 2, D = 1, W = 4, L = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, RS0 = 1'b0, LOCK0 = 1'b0;
  logic       REQ1 = 1'b0, RS1 = 1'b0, LOCK1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       ACK0, ACK1, BUSY, OWNER, TLCD_E, TLCD_RS, TLCD_RW;
  logic [7:0] TLCD_DATA;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  tlcd_bus_scheduler #(
    .E_SETUP_CYC(S), .E_HIGH_CYC(H), .E_HOLD_CYC(D),
    .CMD_WAIT_CYC(W), .LONG_WAIT_CYC(L)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .RS0(RS0), .DATA0(DATA0), .LOCK0(LOCK0), .ACK0(ACK0),
    .REQ1(REQ1), .RS1(RS1), .DATA1(DATA1), .LOCK1(LOCK1), .ACK1(ACK1),
    .BUSY(BUSY), .OWNER(OWNER),
    .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: each grant opens a window of fixed length, outputs derive from offset in it.
  int         edge_no  = 0;
  bit         m_active = 1'b0;
  int         m_t0     = 0;
  int         m_total  = 0;
  bit         m_owner  = 1'b1;
  bit         m_lock   = 1'b0;
  bit         m_rs     = 1'b0;
  logic [7:0] m_data   = 8'h00;

  always @(posedge CLK or posedge RST) begin
    bit lk, r0, r1, w;
    if (RST) begin
      m_active = 1'b0;
      m_owner  = 1'b1;
      m_lock   = 1'b0;
    end else begin
      edge_no++;
      if (m_active) begin
        if (edge_no - m_t0 == m_total) m_active = 1'b0;
      end else begin
        lk = m_lock && (m_owner ? LOCK1 : LOCK0);
        if (!lk) m_lock = 1'b0;
        r0 = REQ0 && (!lk || !m_owner);
        r1 = REQ1 && (!lk || m_owner);
        if (r0 || r1) begin
          w        = (r0 && r1) ? !m_owner : r1;
          m_owner  = w;
          m_lock   = w ? LOCK1 : LOCK0;
          m_rs     = w ? RS1 : RS0;
          m_data   = w ? DATA1 : DATA0;
          m_total  = S + H + D + ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? L : W);
          m_t0     = edge_no;
          m_active = 1'b1;
        end
      end
    end
  end

  // Every cycle: compare all outputs against the model, sampled mid-period.
  always @(negedge CLK) begin
    int   n;
    bit   on_bus, ack;
    n      = edge_no - m_t0 + 1;
    on_bus = m_active && n <= S + H + D;
    ack    = m_active && n == m_total;
    chk("e",     TLCD_E,    m_active && n >= S + 1 && n <= S + H);
    chk("rs",    TLCD_RS,   on_bus ? m_rs : 1'b0);
    chk("data",  TLCD_DATA, on_bus ? m_data : 8'h00);
    chk("rw",    TLCD_RW,   1'b0);
    chk("busy",  BUSY,      m_active);
    chk("owner", OWNER,     m_owner);
    chk("ack0",  ACK0,      ack && !m_owner);
    chk("ack1",  ACK1,      ack && m_owner);
  end

  task automatic reset_dut();
    REQ0 = 0; REQ1 = 0; LOCK0 = 0; LOCK1 = 0;
    RS0 = 0; RS1 = 0; DATA0 = 8'h00; DATA1 = 8'h00;
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Called just after a posedge with a request driven: next posedge is the grant (cycle 0).
  task automatic measure(input bit port, output int lat, output int e_first, output int e_cnt,
                         output int busy_cnt, output int data_cnt);
    lat = -1; e_first = -1; e_cnt = 0; busy_cnt = 0; data_cnt = 0;
    @(posedge CLK);
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (TLCD_E) begin
        e_cnt++;
        if (e_first < 0) e_first = n;
      end
      if (BUSY) busy_cnt++;
      if (TLCD_DATA != 8'h00) data_cnt++;
      if (port ? ACK1 : ACK0) begin
        lat = n;
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  int         lat, ef, ec, bc, dc;
  int         ack_n [4];
  int         ack_p [4];
  int         k, stray, extra;
  logic [8:0] long_tab [7];
  int         long_lat [7];

  initial begin
    long_tab[0] = {1'b0, 8'h01}; long_lat[0] = 14;
    long_tab[1] = {1'b0, 8'h80}; long_lat[1] = 8;
    long_tab[2] = {1'b0, 8'h02}; long_lat[2] = 14;
    long_tab[3] = {1'b0, 8'h03}; long_lat[3] = 14;
    long_tab[4] = {1'b0, 8'h04}; long_lat[4] = 8;
    long_tab[5] = {1'b1, 8'h01}; long_lat[5] = 8;
    long_tab[6] = {1'b0, 8'h00}; long_lat[6] = 8;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_e", TLCD_E, 1'b0);
    chk("reset_data", TLCD_DATA, 8'h00);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_owner", OWNER, 1'b1);

    // Single write on port 1.
    reset_dut();
    REQ1 = 1; RS1 = 1; DATA1 = 8'h41;
    measure(1'b1, lat, ef, ec, bc, dc);
    REQ1 = 0;
    chk("single_ack_lat", lat, 8);
    chk("single_e_first", ef, 2);
    chk("single_e_cnt", ec, 2);
    chk("single_busy_cnt", bc, 8);
    chk("single_data_cnt", dc, 4);

    // Long vs normal waits, back to back on port 0.
    reset_dut();
    REQ0 = 1;
    for (int i = 0; i < 7; i++) begin
      RS0 = long_tab[i][8]; DATA0 = long_tab[i][7:0];
      measure(1'b0, lat, ef, ec, bc, dc);
      chk($sformatf("long_lat_%0d", i), lat, long_lat[i]);
    end
    REQ0 = 0;

    // Contention: both held, round robin from owner=1 after reset.
    reset_dut();
    REQ0 = 1; RS0 = 1; DATA0 = 8'hA0;
    REQ1 = 1; RS1 = 1; DATA1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin ack_n[i] = -1; ack_p[i] = -1; end
    k = 0;
    @(posedge CLK);
    for (int n = 1; n <= 200 && k < 4; n++) begin
      @(negedge CLK);
      if (ACK0 || ACK1) begin
        ack_n[k] = n;
        ack_p[k] = ACK1 ? 1 : 0;
        k++;
      end
    end
    @(posedge CLK);
    #1 REQ0 = 0; REQ1 = 0;
    chk("cont_ack0_cyc", ack_n[0], 8);  chk("cont_ack0_port", ack_p[0], 0);
    chk("cont_ack1_cyc", ack_n[1], 17); chk("cont_ack1_port", ack_p[1], 1);
    chk("cont_ack2_cyc", ack_n[2], 26); chk("cont_ack2_port", ack_p[2], 0);
    chk("cont_ack3_cyc", ack_n[3], 35); chk("cont_ack3_port", ack_p[3], 1);

    // Locked burst on port 0 while port 1 waits, with a REQ gap inside the burst.
    reset_dut();
    REQ1 = 1; RS1 = 1; DATA1 = 8'h99;
    REQ0 = 1; LOCK0 = 1; RS0 = 0; DATA0 = 8'h40;
    stray = 0;
    for (int i = 0; i < 9; i++) begin
      lat = -1;
      @(posedge CLK);
      for (int n = 1; n <= 100; n++) begin
        @(negedge CLK);
        if (ACK1) stray++;
        if (ACK0) begin lat = n; break; end
      end
      chk($sformatf("burst_lat_%0d", i), lat, 8);
      @(posedge CLK);
      #1;
      RS0 = 1; DATA0 = 8'h10 + 8'(i);
      if (i == 3) begin
        REQ0 = 0;
        repeat (5) begin
          @(negedge CLK);
          if (ACK1 || BUSY) stray++;
        end
        @(posedge CLK);
        #1 REQ0 = 1;
      end
      if (i == 8) begin REQ0 = 0; LOCK0 = 0; end
    end
    chk("burst_no_ack1", stray, 0);
    measure(1'b1, lat, ef, ec, bc, dc);
    chk("burst_then_port1_lat", lat, 8);
    REQ1 = 0;

    // Reset while E is high, then the pending request is regranted.
    reset_dut();
    REQ1 = 1; RS1 = 1; DATA1 = 8'h55;
    @(posedge CLK);
    repeat (2) @(negedge CLK);
    chk("midpulse_e_before", TLCD_E, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("midpulse_e", TLCD_E, 1'b0);
    chk("midpulse_data", TLCD_DATA, 8'h00);
    chk("midpulse_busy", BUSY, 1'b0);
    chk("midpulse_ack", {ACK0, ACK1}, 2'b00);
    chk("midpulse_owner", OWNER, 1'b1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    measure(1'b1, lat, ef, ec, bc, dc);
    REQ1 = 0;
    chk("midpulse_regrant_lat", lat, 8);
    chk("midpulse_regrant_data_cnt", dc, 4);

    // Request withdrawn after grant still completes exactly once.
    reset_dut();
    REQ0 = 1; RS0 = 1; DATA0 = 8'h33;
    lat = -1;
    @(posedge CLK);
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (n == 2) #1 REQ0 = 0;
      if (ACK0) begin lat = n; break; end
    end
    chk("withdraw_ack_lat", lat, 8);
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ACK0 || ACK1 || BUSY) extra++;
    end
    chk("withdraw_no_regrant", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlcd_bus_scheduler.md
Name: tlcd_bus_scheduler

Overview:
- Owns the physical Text LCD bus (E/RS/RW/DATA) and serialises single-byte write transactions from two requesters.
  - Port 0: custom font loader (CGRAM writes).
  - Port 1: text refresher (DDRAM writes).
- Generates HD44780 write timing and the post-write execution wait, including the long wait for clear/home.
- Arbitrates round-robin, with an optional lock for multi-byte bursts.
- Replaces the static done-flag mux in the game top level.

Parameters:
- E_SETUP_CYC, 2, cycles RS/DATA are stable before E rises (min 1)
- E_HIGH_CYC, 12, cycles E is held high (min 1)
- E_HOLD_CYC, 2, cycles RS/DATA are held after E falls (min 1)
- CMD_WAIT_CYC, 2000, execution wait after a normal write (min 1)
- LONG_WAIT_CYC, 82000, execution wait after clear/home (min 1)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- REQ0  in  1  requester 0 write request; level, held until ACK0
- RS0  in  1  requester 0 register select (0 = command, 1 = data)
- DATA0  in  8  requester 0 byte
- LOCK0  in  1  requester 0 keeps ownership across consecutive transactions
- ACK0  out  1  one-cycle completion pulse for requester 0
- REQ1, RS1, DATA1, LOCK1, ACK1  same widths and meaning for requester 1
- BUSY  out  1  high whenever state is not IDLE
- OWNER  out  1  index of the last or current granted requester
- TLCD_E  out  1  LCD enable
- TLCD_RS  out  1  LCD register select
- TLCD_RW  out  1  LCD read/write; always 0 (write-only)
- TLCD_DATA  out  8  LCD data bus

Behaviour:
- Reset values:
  - State IDLE.
  - TLCD_E, TLCD_RS, TLCD_RW = 0; TLCD_DATA = 8'h00.
  - ACK0, ACK1, BUSY = 0.
  - OWNER = 1, so requester 0 wins the first contest.
  - Lock flag cleared; counter = 0.
- Reset mid-transaction aborts immediately, even with E high. No ACK is issued.
- States and durations: IDLE -> SETUP (E_SETUP_CYC) -> PULSE (E_HIGH_CYC) -> HOLD (E_HOLD_CYC) -> WAIT (CMD_WAIT_CYC or LONG_WAIT_CYC) -> IDLE.
- One down-counter is loaded on each state entry. Its width is sized by clog2 of the largest parameter.
- Grant happens in IDLE when any eligible REQ is high at the clock edge. That edge is cycle 0.
  - The winner's RS/DATA are captured into TLCD_RS/TLCD_DATA at that edge.
  - OWNER is updated at the same edge.
  - The captured values are held unchanged through HOLD.
  - Requester inputs are ignored after capture.
- Eligibility:
  - If the lock flag is set, only OWNER is eligible.
  - Otherwise both are eligible. If both request, the non-OWNER wins (round-robin). A lone requester always wins.
- Lock:
  - The flag is set at grant if the winner's LOCK is high.
  - It is cleared in IDLE when OWNER's LOCK is low.
  - While locked and OWNER has no REQ, the scheduler idles and does not serve the other requester.
- TLCD_E is 1 only in PULSE. TLCD_DATA/TLCD_RS return to 0 in WAIT and IDLE.
- Long wait is used when the captured RS = 0 and DATA is 8'h01, 8'h02 or 8'h03. All other writes use CMD_WAIT_CYC.
- ACKn is high during the last WAIT cycle only, for the granted requester.
  - Latency: ACK is high in cycle S+H+D+W after grant cycle 0.
- The requester drops or updates REQ/RS/DATA at the ACK edge.
  - The next IDLE cycle may grant again. Minimum back-to-back spacing is S+H+D+W+1 cycles.
- REQ withdrawn after grant: the transaction still completes and ACK still pulses.
- REQ without a prior grant may be withdrawn freely; no side effects.
- BUSY is asserted from cycle 1 through the ACK cycle and deasserted in IDLE.

Test Plan:
All scenarios use parameters S=1, H=2, D=1, W=4, L=10.
- Single write: REQ1 with RS1=1, DATA1=8'h41 -> E high cycles 2-3; TLCD_DATA=8'h41 during cycles 1-4; ACK1 pulses at cycle 8; BUSY high in cycles 1-8.
- Long command: REQ0 with RS0=0, DATA0=8'h01 -> ACK0 at cycle 14. Same request with DATA0=8'h80 -> ACK0 at cycle 8.
- Contention: REQ0 and REQ1 both held continuously after reset -> grant order 0, 1, 0, 1; ACKs at cycles 8, 17, 26, 35.
- Lock burst: LOCK0=1 for 9 writes (8'h40 then 8 CGRAM bytes) while REQ1 is held -> all 9 served to requester 0; LOCK0 drops after the 9th ACK -> requester 1 granted in the next IDLE.
- Reset mid-PULSE: assert RST while E=1 -> all outputs 0 immediately; no ACK; after release, the pending REQ1 is regranted from cycle 0.
- Early withdrawal: REQ0 dropped at cycle 2 -> transaction completes; ACK0 still pulses at cycle 8; no second grant.
